// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: monitors a time-multiplexed, active-low 7-segment bus and
// recovers the multi-digit hex value being displayed.
//
// Each digit's pattern must hold for STABLE_CYCLES consecutive samples before it
// is decoded. Once every digit has been captured, the assembled value is
// published with a one-cycle valid pulse. A pattern that is not a hex glyph and
// not dark raises a one-cycle err pulse and discards the partial frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (released synchronously inside)
//   an_i         active-low digit enables, bit i low = digit i driven
//   seg_i        active-low segments {g,f,e,d,c,b,a}
//   value_o      last complete frame, digit i at [4i+3:4i]
//   blank_o      bit i set = digit i was dark in the last complete frame
//   valid_o      one-cycle pulse when value_o/blank_o update
//   err_o        one-cycle pulse when an undecodable pattern is captured
//   err_digit_o  digit index of the most recent err, held until the next one
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [6:0]              seg_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    valid_o,
    output logic                    err_o,
    output logic [IDX_W-1:0]        err_digit_o
);

    localparam logic [7:0] LastCnt = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

    // Reset synchroniser: assert asynchronously, release on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Input sample registers and the previous sample for the stability check.
    logic [NUM_DIGITS-1:0] s_an_q, p_an_q;
    logic [6:0]            s_seg_q, p_seg_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s_an_q  <= '1;
            s_seg_q <= '1;
            p_an_q  <= '1;
            p_seg_q <= '1;
        end else begin
            s_an_q  <= an_i;
            s_seg_q <= seg_i;
            p_an_q  <= s_an_q;
            p_seg_q <= s_seg_q;
        end
    end

    logic same;
    assign same = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);

    // Active digit: exactly one enable low.
    logic [3:0]       n_low;
    logic [IDX_W-1:0] act_idx;
    logic             active;

    always_comb begin
        n_low   = 4'd0;
        act_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an_q[i]) begin
                n_low   = n_low + 4'd1;
                act_idx = IDX_W'(i);
            end
        end
        active = (n_low == 4'd1);
    end

    // Returns {ok, dark, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h40:   r = {2'b10, 4'h0};
            7'h79:   r = {2'b10, 4'h1};
            7'h24:   r = {2'b10, 4'h2};
            7'h30:   r = {2'b10, 4'h3};
            7'h19:   r = {2'b10, 4'h4};
            7'h12:   r = {2'b10, 4'h5};
            7'h02:   r = {2'b10, 4'h6};
            7'h78:   r = {2'b10, 4'h7};
            7'h00:   r = {2'b10, 4'h8};
            7'h18:   r = {2'b10, 4'h9};
            7'h08:   r = {2'b10, 4'hA};
            7'h03:   r = {2'b10, 4'hB};
            7'h46:   r = {2'b10, 4'hC};
            7'h21:   r = {2'b10, 4'hD};
            7'h06:   r = {2'b10, 4'hE};
            7'h0E:   r = {2'b10, 4'hF};
            7'h7F:   r = {2'b11, 4'h0};
            default: r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    // FSM: state register.
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (active) begin
                    cnt_d   = 8'd1;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!active) begin
                    state_d = StIdle;
                end else if (!same) begin
                    cnt_d = 8'd1;
                end else if (cnt_q >= LastCnt) begin
                    state_d = StHeld;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHeld: begin
                if (!same) begin
                    if (active) begin
                        cnt_d   = 8'd1;
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    logic capture;

    always_comb begin
        capture = 1'b0;
        if (state_q == StSettle && active && same && cnt_q >= LastCnt) begin
            capture = 1'b1;
        end
    end

    // Frame assembly.
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d, value_q, value_d;
    logic [NUM_DIGITS-1:0]      shblank_q, shblank_d, blank_q, blank_d;
    logic [NUM_DIGITS-1:0]      captured_q, captured_d;
    logic                       valid_q, valid_d, err_q, err_d;
    logic [IDX_W-1:0]           err_digit_q, err_digit_d;
    logic [5:0]                 dec;
    logic                       complete;

    assign dec      = decode(s_seg_q);
    assign complete = &captured_q;

    always_comb begin
        shadow_d    = shadow_q;
        shblank_d   = shblank_q;
        captured_d  = complete ? '0 : captured_q;
        value_d     = complete ? shadow_q : value_q;
        blank_d     = complete ? shblank_q : blank_q;
        valid_d     = complete;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        if (capture) begin
            if (dec[5]) begin
                shadow_d[act_idx]   = dec[3:0];
                shblank_d[act_idx]  = dec[4];
                captured_d[act_idx] = 1'b1;
            end else begin
                // Undecodable glyph: the whole partial frame is untrustworthy.
                err_d       = 1'b1;
                err_digit_d = act_idx;
                captured_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            shadow_q    <= '0;
            shblank_q   <= '0;
            captured_q  <= '0;
            value_q     <= '0;
            blank_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            shblank_q   <= shblank_d;
            captured_q  <= captured_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign value_o     = value_q;
    assign blank_o     = blank_q;
    assign valid_o     = valid_q;
    assign err_o       = err_q;
    assign err_digit_o = err_digit_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart to the team's hex-to-7-segment encoder.
- Watches a time-multiplexed, active-low 7-segment display bus (digit enables plus shared segment lines).
- Waits until each digit's pattern has been stable long enough, decodes it back to a hex nibble, and assembles a full multi-digit value.
- Used as an on-chip display monitor and as a self-check block in display test benches.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is decoded (2..255).
- IDX_W, 2, width of the digit index; must be ≥ clog2(NUM_DIGITS).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  NUM_DIGITS  active-low digit enables; bit i low = digit i driven.
- seg  in  7  active-low segments {g,f,e,d,c,b,a} = seg[6:0], same bit order as the encoder.
- value  out  4*NUM_DIGITS  last complete captured value; digit i at [4i+3:4i].
- blank  out  NUM_DIGITS  bit i set = digit i was dark (seg=7'h7F) in the last complete frame.
- valid  out  1  one-cycle pulse when value/blank update.
- err  out  1  one-cycle pulse when an undecodable pattern is captured.
- err_digit  out  IDX_W  digit index of the most recent err; holds until the next err.

Behaviour:
- Reset (async assert, sync deassert internally): value=0, blank=0, valid=0, err=0, err_digit=0, sample regs=all-ones, counter=0, captured mask=0, shadow=0, FSM=IDLE.
- Input stage: an and seg are registered once (s_an, s_seg); all decisions use the registered copies.
- Active digit: s_an has exactly one zero bit; its index is act_idx. Zero or multiple low bits = no active digit.
- FSM:
  - IDLE: waits for an active digit. On one: counter=1, go SETTLE.
  - SETTLE: sample equal to previous sample → counter+1. When counter reaches STABLE_CYCLES-1 and the sample is still equal, capture on that edge and go HELD. Sample change → counter=1, stay SETTLE. No active digit → IDLE.
  - HELD: stays while the sample is unchanged; no re-capture. Any change → SETTLE with counter=1, or IDLE if no active digit.
- Capture decode (inverse of the encoder table):
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
  - 0x7F: nibble=0, shadow blank bit set.
  - Match: shadow nibble[act_idx] written, blank bit updated, captured[act_idx] set. A re-capture of an already-captured digit overwrites it.
  - No match: err=1 next cycle, err_digit=act_idx, captured mask cleared (frame discarded), shadow unchanged.
- Frame completion: when captured becomes all-ones, on the next edge value←shadow nibbles, blank←shadow blanks, valid=1 for exactly one cycle, captured←0.
- Latency: a digit stable on an/seg from cycle t is captured at edge t+STABLE_CYCLES (1 input register + STABLE_CYCLES-1 counts). valid rises one cycle after the last digit's capture.
- Simultaneous err and completion cannot occur; err takes the captured mask to 0 first.
- Counter saturates and never wraps; its width is 8 bits.
- rst_n low mid-frame drops all partial state; no valid is produced for the interrupted frame.
- value and blank change only with a valid pulse.

Test Plan:
- Reset: hold rst_n=0 with random an/seg → value=0, blank=0, valid=0, err=0. Release → no pulses until a full frame is captured.
- Full frame: scan digits 0..3 with 0x30,0x12,0x46,0x0E (3,5,C,F), 20 cycles each, STABLE_CYCLES=8 → one valid pulse, value=16'hFC53, blank=4'b0000, err never asserted.
- Stability filter: digit 0 shows 0x24 for 5 cycles, then 0x40 for 7 cycles → no capture. Then 0x40 for 8+ cycles → digit 0 captured as 0 exactly 8 cycles after the 0x40 dwell starts.
- Invalid pattern: digit 2 shows 0x55 stable for 10 cycles mid-frame → err pulse, err_digit=2, captured mask cleared. Next clean frame yields exactly one valid.
- Blank and ghost: digit 1 shows 0x7F; a 3-cycle window with an=4'b0000 is inserted between digits → frame completes with blank=4'b0010 and value[7:4]=0. The ghost window causes no capture or err.
- Reset mid-frame: pull rst_n low after 2 of 4 digits are captured, release, then scan a full frame of all 8s (0x00) → a single valid, value=16'h8888, no stale nibbles.
